lopd_pipe: RTL and testbench

- Parametrised, pipelined leading/trailing-one position detector with valid/ready handshake.
- Generalises the combinational position detector used in the logarithmic multiplier path. Adds selectable search direction, zero flag, Mitchell-style normalised fraction output, sideband tag, and backpressure.
- Sits between operand registers and the log-domain adder in the multiplier datapath.
- Two-stage pipeline with full throughput of one result per cycle.

---
 rtl/lopd_pkg.sv | 15 +
 rtl/lopd_group.sv | 28 ++
 rtl/lopd_pipe.sv | 142 ++++++++++++++
 tb/tb_lopd_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lopd_pkg.sv
// Shared constants and helpers for the leading/trailing-one position detector.
package lopd_pkg;

  localparam logic LOPD_MODE_LEAD  = 1'b0;
  localparam logic LOPD_MODE_TRAIL = 1'b1;
  localparam int   LOPD_GROUP_DEF  = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/lopd_group.sv
// Combinational one-detector over a small vector: any-one flag plus index of
// the highest (lead) or lowest (trail) set bit.
module lopd_group
  import lopd_pkg::*;
#(
  parameter int GROUP = LOPD_GROUP_DEF,
  parameter int IDX_W = (clog2(GROUP) > 0) ? clog2(GROUP) : 1
) (
  input  logic [GROUP-1:0] bits,
  input  logic             mode,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // Later matches overwrite earlier ones, so scan order picks the winner.
  always_comb begin
    hit = |bits;
    idx = '0;
    if (mode == LOPD_MODE_LEAD) begin
      for (int i = 0; i < GROUP; i++)
        if (bits[i]) idx = IDX_W'(i);
    end else begin
      for (int i = GROUP - 1; i >= 0; i--)
        if (bits[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/lopd_pipe.sv
// Two-stage pipelined leading/trailing-one detector with Mitchell fraction
// output, sideband tag and valid/ready backpressure.
module lopd_pipe
  import lopd_pkg::*;
#(
  parameter int WIDTH_I = 16,
  parameter int GROUP   = LOPD_GROUP_DEF,
  parameter int WIDTH_L = clog2(WIDTH_I),
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_I-1:0] in_data,
  input  logic               in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_L-1:0] out_pos,
  output logic               out_zero,
  output logic [WIDTH_I-2:0] out_frac,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int NG     = WIDTH_I / GROUP;
  localparam int LIDX_W = clog2(GROUP);
  localparam int GIDX_W = (clog2(NG) > 0) ? clog2(NG) : 1;

  generate
    if (WIDTH_I % GROUP != 0) begin : g_bad_width
      $error("lopd_pipe: WIDTH_I must be a multiple of GROUP");
    end
  endgenerate

  function automatic logic [WIDTH_I-2:0] norm_frac(input logic [WIDTH_I-1:0] data,
                                                   input logic [WIDTH_L-1:0] pos);
    logic [WIDTH_I-1:0] sh;
    sh = data << (WIDTH_L'(WIDTH_I - 1) - pos);
    return sh[WIDTH_I-2:0];
  endfunction

  logic                          vld_p1, mode_p1;
  logic [NG-1:0]                 hit_p1;
  logic [NG-1:0][LIDX_W-1:0]     lidx_p1;
  logic [WIDTH_I-1:0]            data_p1;
  logic [TAG_W-1:0]              tag_p1;

  logic                          vld_p2, zero_p2;
  logic [WIDTH_L-1:0]            pos_p2;
  logic [WIDTH_I-2:0]            frac_p2;
  logic [TAG_W-1:0]              tag_p2;

  logic s1_ready, s2_ready;

  assign s2_ready = !vld_p2 || out_ready;
  assign s1_ready = !vld_p1 || s2_ready;
  assign in_ready = s1_ready;

  // ---- stage 1: per-group detection on the incoming word
  logic [NG-1:0]             hit_c;
  logic [NG-1:0][LIDX_W-1:0] lidx_c;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    lopd_group #(.GROUP(GROUP), .IDX_W(LIDX_W)) u_grp (
      .bits (in_data[g*GROUP +: GROUP]),
      .mode (in_mode),
      .hit  (hit_c[g]),
      .idx  (lidx_c[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      hit_p1  <= '0;
      lidx_p1 <= '0;
      data_p1 <= '0;
      mode_p1 <= 1'b0;
      tag_p1  <= '0;
    end else if (s1_ready) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        hit_p1  <= hit_c;
        lidx_p1 <= lidx_c;
        data_p1 <= in_data;
        mode_p1 <= in_mode;
        tag_p1  <= in_tag;
      end
    end
  end

  // ---- stage 2: group select, position assembly, fraction normalisation
  logic                gsel_hit;
  logic [GIDX_W-1:0]   gsel;
  logic [LIDX_W-1:0]   lsel;
  logic [WIDTH_L-1:0]  pos_c;
  logic [WIDTH_I-2:0]  frac_c;

  lopd_group #(.GROUP(NG), .IDX_W(GIDX_W)) u_gsel (
    .bits (hit_p1),
    .mode (mode_p1),
    .hit  (gsel_hit),
    .idx  (gsel)
  );

  always_comb begin
    lsel   = lidx_p1[gsel];
    pos_c  = '0;
    frac_c = '0;
    if (gsel_hit) begin
      pos_c = WIDTH_L'(int'(gsel) * GROUP + int'(lsel));
      if (mode_p1 == LOPD_MODE_LEAD) frac_c = norm_frac(data_p1, pos_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      pos_p2  <= '0;
      zero_p2 <= 1'b0;
      frac_p2 <= '0;
      tag_p2  <= '0;
    end else if (s2_ready) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        pos_p2  <= pos_c;
        zero_p2 <= !gsel_hit;
        frac_p2 <= frac_c;
        tag_p2  <= tag_p1;
      end
    end
  end

  // ---- output
  assign out_valid = vld_p2;
  assign out_pos   = pos_p2;
  assign out_zero  = zero_p2;
  assign out_frac  = frac_p2;
  assign out_tag   = tag_p2;

endmodule

// File: tb/tb_lopd_pipe.sv
// Bench for lopd_pipe: vector table plus scoreboard, backpressure and reset sequences.
module tb_lopd_pipe;
  import lopd_pkg::*;

  typedef struct packed {
    logic [3:0]  pos;
    logic        zero;
    logic [14:0] frac;
    logic [3:0]  tag;
  } exp_t;

  typedef struct packed {
    logic [15:0] data;
    logic        mode;
    exp_t        e;
  } vec_t;

  localparam int NV = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_zero;
  logic [15:0] in_data;
  logic [3:0]  in_tag, out_pos, out_tag;
  logic [14:0] out_frac;

  exp_t  sb[$];
  exp_t  cur_exp;
  vec_t  vecs[NV];
  int    tests = 0;
  int    fails = 0;
  logic        stall_prev = 1'b0;
  logic [23:0] stall_snap;
  logic        saw_block = 1'b0;

  always #5 clk = ~clk;

  lopd_pipe #(.WIDTH_I(16), .GROUP(4), .WIDTH_L(4), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pos   (out_pos),
    .out_zero  (out_zero),
    .out_frac  (out_frac),
    .out_tag   (out_tag)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Independent reference: bitwise scan, fraction built bit by bit.
  function automatic exp_t model(input logic [15:0] d, input logic m, input logic [3:0] t);
    exp_t e;
    int   p;
    e.tag = t; e.zero = (d == 16'h0); e.pos = '0; e.frac = '0;
    if (d != 16'h0) begin
      if (m == 1'b0) begin
        for (int i = 0; i < 16; i++) if (d[i]) e.pos = 4'(i);
        p = int'(e.pos);
        for (int k = 0; k < p; k++) e.frac[15 - p + k] = d[k];
      end else begin
        for (int i = 15; i >= 0; i--) if (d[i]) e.pos = 4'(i);
      end
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic [15:0] d, input logic m, input logic [3:0] t,
                              input logic [3:0] pos, input logic z, input logic [14:0] f);
    vec_t v;
    v.data = d; v.mode = m;
    v.e.pos = pos; v.e.zero = z; v.e.frac = f; v.e.tag = t;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_valid = 1'b1; in_data = v.data; in_mode = v.mode; in_tag = v.e.tag;
    cur_exp  = v.e;
  endtask

  task automatic send(input vec_t v);
    int n;
    n = 0;
    drive(v);
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (in_valid && in_ready) sb.push_back(cur_exp);
      if (!in_ready) saw_block = 1'b1;
      if (out_valid && out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL result: unexpected output pos=%0d tag=%h, required none", out_pos, out_tag);
        end else begin
          e = sb.pop_front();
          if ({out_pos, out_zero, out_frac, out_tag} !== e) begin
            fails++;
            $display("FAIL result: got pos=%0d zero=%0b frac=%h tag=%h, required pos=%0d zero=%0b frac=%h tag=%h",
                     out_pos, out_zero, out_frac, out_tag, e.pos, e.zero, e.frac, e.tag);
          end
        end
      end
      if (out_valid && !out_ready) begin
        if (stall_prev) chk("stall_hold", {8'h0, out_pos, out_zero, out_frac, out_tag}, {8'h0, stall_snap});
        stall_prev = 1'b1;
        stall_snap = {out_pos, out_zero, out_frac, out_tag};
      end else begin
        stall_prev = 1'b0;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    logic stale;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_tag = '0;
    out_ready = 1'b1; cur_exp = '0;

    vecs[0]  = mk(16'h0013, 1'b0, 4'h3, 4'd4,  1'b0, 15'h1800);
    vecs[1]  = mk(16'h8001, 1'b0, 4'h5, 4'd15, 1'b0, 15'h0001);
    vecs[2]  = mk(16'h0001, 1'b0, 4'h6, 4'd0,  1'b0, 15'h0000);
    vecs[3]  = mk(16'h0140, 1'b1, 4'h7, 4'd6,  1'b0, 15'h0000);
    vecs[4]  = mk(16'h0140, 1'b0, 4'h8, 4'd8,  1'b0, 15'h2000);
    vecs[5]  = mk(16'h0000, 1'b0, 4'h1, 4'd0,  1'b1, 15'h0000);
    vecs[6]  = mk(16'h0000, 1'b1, 4'h2, 4'd0,  1'b1, 15'h0000);
    vecs[7]  = mk(16'hFFFF, 1'b1, 4'hA, 4'd0,  1'b0, 15'h0000);
    vecs[8]  = mk(16'h8000, 1'b1, 4'hB, 4'd15, 1'b0, 15'h0000);
    vecs[9]  = mk(16'h1234, 1'b0, 4'hC, 4'd12, 1'b0, 15'h11A0);
    vecs[10] = mk(16'h8000, 1'b0, 4'hD, 4'd15, 1'b0, 15'h0000);

    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_fields", {8'h0, out_pos, out_zero, out_frac, out_tag}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // First vector: two-edge latency from launch to out_valid
    drive(vecs[0]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("latency_edge1", out_valid, 0);
    @(posedge clk); #1;
    chk("latency_edge2", out_valid, 1);

    for (int i = 1; i < NV; i++) send(vecs[i]);
    drain();

    // Backpressure: 6 random beats, out_ready low for cycles 3-6
    saw_block = 1'b0;
    fork
      begin : bp_drv
        vec_t v;
        for (int i = 0; i < 6; i++) begin
          v.data = 16'($urandom);
          v.mode = 1'($urandom_range(0, 1));
          v.e    = model(v.data, v.mode, 4'(i + 4));
          send(v);
        end
        in_valid = 1'b0;
      end
      begin : bp_rdy
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    chk("bp_in_ready_low", saw_block, 1);
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(mk(16'h00F0, 1'b0, 4'h1, 4'd7, 1'b0, 15'h7000));
    send(mk(16'h0F00, 1'b1, 4'h2, 4'd8, 1'b0, 15'h0000));
    chk("inflight_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_clear_valid", out_valid, 0);
    chk("async_clear_fields", {8'h0, out_pos, out_zero, out_frac, out_tag}, 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_reset_in_ready", in_ready, 1);
    stale = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    chk("no_stale_result", stale, 0);
    @(posedge clk); #1;
    send(mk(16'h0400, 1'b0, 4'h9, 4'd10, 1'b0, 15'h0000));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
